cur_blk_load_ctrl: RTL and testbench
====================================

CUR_BLK_LOAD_CTRL -- requirements
Module: cur_blk_load_ctrl

Interface
REQ-001 Parameter FRAME_W, default 1024, frame width in pixels (multiple of 16).
REQ-002 Parameter ADDR_W, default 20, memory word-address width (64-bit words).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse requesting load of one 16x16 current block.
REQ-006 mb_x  in  8  macroblock column index.
REQ-007 mb_y  in  8  macroblock row index.
REQ-008 base_addr  in  ADDR_W  word address of frame pixel (0,0).
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  one-cycle pulse when all 32 words are written.
REQ-011 bus_req  out  1  memory bus request to shared arbiter.
REQ-012 bus_gnt  in  1  arbiter grant; held high while bus_req high once given.
REQ-013 mem_addr  out  ADDR_W  read address; mem_rd  out  1  read strobe.
REQ-014 mem_rdata  in  64  read data, valid exactly 1 cycle after mem_rd.
REQ-015 blk_we  out  1  write enable to current-block register file.
REQ-016 blk_data  out  64  8 pixels, MSB byte = leftmost pixel.
REQ-017 err  out  1  sticky protocol-error flag (see Configuration).

Function
REQ-018 FSM states IDLE, REQ, READ, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: start=1 latches mb_x, mb_y, base_addr -> REQ; start in any other state is ignored.
REQ-020 REQ: bus_req=1; bus_gnt=1 -> READ.
REQ-021 READ: mem_rd=1 every cycle for exactly 32 cycles, beat counter k=0..31, no gaps.
REQ-022 Address of beat k: base_addr + (mb_y*16 + k[4:1])*(FRAME_W/8) + mb_x*2 + k[0], modulo 2^ADDR_W.
REQ-023 blk_we = mem_rd delayed 1 cycle; blk_data = mem_rdata, unregistered; yields 32 contiguous WE cycles, required because the register file restarts its write index whenever WE drops.
REQ-024 After beat 31: READ -> DRAIN (last write) -> DONE (done=1, busy=0 next) -> IDLE.
REQ-025 bus_req high in REQ and READ; low from DRAIN onward.
REQ-026 Latency: grant sampled at cycle g -> mem_rd g+1..g+32 -> blk_we g+2..g+33 -> done at g+34.
REQ-027 busy=1 in REQ, READ, DRAIN; 0 in IDLE and DONE.
REQ-028 A start in the DONE cycle is ignored; a new load requires a start in IDLE.
REQ-029 The beat counter is 5 bits and terminates at 31; it never wraps into a 33rd read.

Reset
REQ-030 reset_n low asynchronously forces IDLE, counter 0, and busy, done, bus_req, mem_rd, blk_we, err to 0; mem_addr to 0.
REQ-031 Reset mid-load abandons the load with no done pulse; the register file is reset by the same reset.

Configuration
REQ-032 With CUR_LOAD_CHECK_EN defined, err is set when bus_gnt=0 during READ or when start=1 while busy=1, and is cleared only by reset.
REQ-033 Without CUR_LOAD_CHECK_EN, err is tied 0 and no checking logic exists; the FSM behaves identically in both builds.

Structure
REQ-034 The shared package holds the FSM state enum, BLK_WORDS=32, WORDS_PER_ROW=2 and PIX_W=8.
REQ-035 One sub-module, cur_blk_addr_gen, computes REQ-022 from the latched coordinates and the beat counter.
REQ-036 The register file is instantiated by the parent, not inside this block.

Verification
REQ-037 mb_x=0, mb_y=0, base=0, gnt immediate: addresses 0,1,128,129,...,1920,1921; 32 WE cycles; done at g+34.
REQ-038 mb_x=3, mb_y=2, base=0x100: first address 0x100+32*128+6=0x1106, last 0x1106+15*128+1=0x1887.
REQ-039 Grant delayed 10 cycles: bus_req held; no mem_rd until grant; then timing per REQ-026.
REQ-040 start pulsed in READ: ignored, single done; with CUR_LOAD_CHECK_EN err=1 and sticky.
REQ-041 reset_n low at beat 15: all outputs 0 immediately; no done; a fresh start completes normally.
REQ-042 Register-file contents after a load equal the 16x16 reference pixels byte-for-byte; two back-to-back loads are both correct.

Source files
------------

// File: rtl/cur_blk_load_ctrl_pkg.sv
// Shared definitions for the current-block load controller:
// FSM state encoding and block geometry constants.
package cur_blk_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // 16x16 block = 16 rows of 2 words of 8 pixels
    localparam int BLK_WORDS     = 32;
    localparam int WORDS_PER_ROW = 2;
    localparam int PIX_W         = 8;
    localparam int BLK_ROWS      = 16;
    localparam int WORD_W        = 64;
    localparam int WORD_PIX      = WORD_W / PIX_W;
    localparam int BEAT_W        = $clog2(BLK_WORDS);

endpackage

// File: rtl/cur_blk_addr_gen.sv
// Word address of one beat of a 16x16 block read. Beat k covers block
// row k[4:1], left or right half k[0]. Arithmetic wraps at 2^ADDR_W.
module cur_blk_addr_gen
    import cur_blk_load_ctrl_pkg::*;
#(
    parameter int FRAME_W = 1024,
    parameter int ADDR_W  = 20
) (
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        mb_x,
    input  logic [7:0]        mb_y,
    input  logic [BEAT_W-1:0] beat,
    output logic [ADDR_W-1:0] addr
);

    // 64-bit words per frame line
    localparam int ROW_WORDS = FRAME_W / WORD_PIX;

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] col_off;

    // Frame row index times line pitch, plus horizontal word offset
    always_comb begin
        row     = ADDR_W'(mb_y) * ADDR_W'(BLK_ROWS) + ADDR_W'(beat[BEAT_W-1:1]);
        row_off = row * ADDR_W'(ROW_WORDS);
        col_off = ADDR_W'(mb_x) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(beat[0]);
        addr    = base_addr + row_off + col_off;
    end

endmodule

// File: rtl/cur_blk_load_ctrl.sv
// Current-block load controller: on start, requests the shared bus,
// reads 32 contiguous words of a 16x16 block and streams them to the
// current-block register file with an unbroken write-enable run.
// Optional protocol checking is enabled by defining CUR_LOAD_CHECK_EN.
module cur_blk_load_ctrl
    import cur_blk_load_ctrl_pkg::*;
#(
    parameter int FRAME_W = 1024,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        mb_x,
    input  logic [7:0]        mb_y,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [63:0]       mem_rdata,
    output logic              blk_we,
    output logic [63:0]       blk_data,
    output logic              err
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_WORDS - 1);

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [7:0]          mb_x_reg, mb_y_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic                blk_we_reg;
    logic [ADDR_W-1:0]   beat_addr;

    cur_blk_addr_gen #(
        .FRAME_W (FRAME_W),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .base_addr (base_reg),
        .mb_x      (mb_x_reg),
        .mb_y      (mb_y_reg),
        .beat      (beat_reg),
        .addr      (beat_addr)
    );

    // State, beat counter, latched request and write-enable delay line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            beat_reg   <= '0;
            mb_x_reg   <= '0;
            mb_y_reg   <= '0;
            base_reg   <= '0;
            blk_we_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            blk_we_reg <= mem_rd;
            if (state_reg == ST_IDLE && start) begin
                mb_x_reg <= mb_x;
                mb_y_reg <= mb_y;
                base_reg <= base_addr;
            end
        end
    end

    // Next-state and Moore outputs; start is only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        busy       = 1'b0;
        done       = 1'b0;
        bus_req    = 1'b0;
        mem_rd     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                beat_next = '0;
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                mem_rd  = 1'b1;
                if (beat_reg == LAST_BEAT) begin
                    beat_next  = '0;
                    state_next = ST_DRAIN;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address is only meaningful while reading; hold it at zero otherwise
    assign mem_addr = mem_rd ? beat_addr : '0;
    assign blk_we   = blk_we_reg;
    assign blk_data = mem_rdata;

`ifdef CUR_LOAD_CHECK_EN
    logic err_reg;

    // Sticky flag: grant lost mid-burst, or start while a load is active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_READ && !bus_gnt) || (start && busy)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cur_blk_load_ctrl.sv
// Directed self-checking bench for cur_blk_load_ctrl (default parameters).
// Memory word content is a fixed function of its address; the register
// file model restarts its write index whenever blk_we drops.
module tb_cur_blk_load_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [7:0]        mb_x, mb_y;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, bus_req, bus_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [63:0]       mem_rdata;
    logic              blk_we;
    logic [63:0]       blk_data;
    logic              err;

    int checks = 0;
    int errors = 0;

    cur_blk_load_ctrl #(.FRAME_W(1024), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mb_x      (mb_x),
        .mb_y      (mb_y),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .blk_we    (blk_we),
        .blk_data  (blk_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input logic [ADDR_W-1:0] a);
        return {a, 4'h5, ~a, 4'hA, a[15:0] ^ 16'h3C96};
    endfunction

    // Memory model: one-cycle read latency
    always @(posedge clk) mem_rdata <= mem_rd ? word_of(mem_addr) : 64'h0;

    // Register file model
    logic [63:0] rf [32];
    int          rf_idx;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_idx <= 0;
        end else if (blk_we) begin
            if (rf_idx < 32) rf[rf_idx] <= blk_data;
            rf_idx <= rf_idx + 1;
        end else begin
            rf_idx <= 0;
        end
    end

    // Cycle counter and negedge activity monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              mon_clr = 1'b0;
    logic              g_seen;
    int                g_cyc, rd_cnt, we_cnt, req_cnt, done_cnt;
    int                first_rd, last_rd, first_we, last_we, last_req, done_cyc;
    logic              done_busy;
    logic [ADDR_W-1:0] addr_log [64];

    always @(negedge clk) begin
        if (mon_clr) begin
            g_seen <= 1'b0; g_cyc <= -1; rd_cnt <= 0; we_cnt <= 0; req_cnt <= 0;
            done_cnt <= 0; first_rd <= -1; last_rd <= -1; first_we <= -1;
            last_we <= -1; last_req <= -1; done_cyc <= -1; done_busy <= 1'b1;
        end else begin
            if (bus_req && bus_gnt && !g_seen) begin
                g_seen <= 1'b1;
                g_cyc  <= cyc;
            end
            if (bus_req) begin
                req_cnt  <= req_cnt + 1;
                last_req <= cyc;
            end
            if (mem_rd) begin
                if (rd_cnt < 64) addr_log[rd_cnt] <= mem_addr;
                if (rd_cnt == 0) first_rd <= cyc;
                last_rd <= cyc;
                rd_cnt  <= rd_cnt + 1;
            end
            if (blk_we) begin
                if (we_cnt == 0) first_we <= cyc;
                last_we <= cyc;
                we_cnt  <= we_cnt + 1;
            end
            if (done) begin
                done_cnt  <= done_cnt + 1;
                done_cyc  <= cyc;
                done_busy <= busy;
            end
        end
    end

    // One block load with grant delay d; mode 1 pulses start during READ,
    // mode 2 pulses start in the DONE cycle. Timing is checked against g.
    task automatic run_load(input int x, input int y, input logic [ADDR_W-1:0] base,
                            input int d, input int mode, input string name);
        int   to;
        logic pulsed, got_done;
        int   g;
        logic [ADDR_W-1:0] ea;
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        mb_x = x[7:0]; mb_y = y[7:0]; base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (!bus_req && to < 10) begin @(negedge clk); to++; end
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL %s bus_req_rise got %b want 1", name, bus_req);
        end
        repeat (d) @(negedge clk);
        bus_gnt = 1'b1;
        pulsed = 1'b0; got_done = 1'b0; to = 0;
        while (!got_done && to < 80) begin
            @(negedge clk); to++;
            start = 1'b0;
            if (mode == 1 && mem_rd && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
            if (done) begin got_done = 1'b1; if (mode == 2) start = 1'b1; end
        end
        checks++;
        if (got_done !== 1'b1) begin
            errors++; $display("FAIL %s done_timeout got %b want 1", name, got_done);
        end
        @(negedge clk);
        start = 1'b0; bus_gnt = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s idle_after got req=%b busy=%b want 0 0", name, bus_req, busy);
        end
        g = g_cyc;
        checks++;
        if (rd_cnt !== 32) begin errors++; $display("FAIL %s rd_cnt got %0d want 32", name, rd_cnt); end
        checks++;
        if (we_cnt !== 32) begin errors++; $display("FAIL %s we_cnt got %0d want 32", name, we_cnt); end
        checks++;
        if (first_rd !== g + 1 || last_rd !== g + 32) begin
            errors++; $display("FAIL %s rd_window got %0d..%0d want %0d..%0d", name, first_rd, last_rd, g + 1, g + 32);
        end
        checks++;
        if (first_we !== g + 2 || last_we !== g + 33) begin
            errors++; $display("FAIL %s we_window got %0d..%0d want %0d..%0d", name, first_we, last_we, g + 2, g + 33);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== g + 34) begin
            errors++; $display("FAIL %s done got cnt=%0d cyc=%0d want 1 %0d", name, done_cnt, done_cyc, g + 34);
        end
        checks++;
        if (done_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, done_busy); end
        checks++;
        if (req_cnt !== d + 33 || last_req !== g + 32) begin
            errors++; $display("FAIL %s bus_req got cnt=%0d last=%0d want %0d %0d", name, req_cnt, last_req, d + 33, g + 32);
        end
        for (int k = 0; k < 32; k++) begin
            ea = ADDR_W'(base + ADDR_W'((y * 16 + k / 2) * 128 + x * 2 + k % 2));
            checks++;
            if (addr_log[k] !== ea) begin
                errors++; $display("FAIL %s addr[%0d] got %h want %h", name, k, addr_log[k], ea);
            end
        end
        $display("load %s x=%0d y=%0d base=%h gnt_dly=%0d g=%0d done=%0d", name, x, y, base, d, g, done_cyc);
    endtask

    // Byte-for-byte register-file comparison against frame pixels
    task automatic check_rf(input int x, input int y, input logic [ADDR_W-1:0] base, input string name);
        logic [63:0]       src, exp_w;
        logic [ADDR_W-1:0] a;
        int                c;
        for (int w = 0; w < 32; w++) begin
            exp_w = '0;
            for (int p = 0; p < 8; p++) begin
                c = (w % 2) * 8 + p;
                a = ADDR_W'(base + ADDR_W'((y * 16 + w / 2) * 128 + (x * 16 + c) / 8));
                src = word_of(a);
                exp_w[63 - 8 * p -: 8] = src[63 - 8 * (c % 8) -: 8];
            end
            checks++;
            if (rf[w] !== exp_w) begin
                errors++; $display("FAIL %s rf[%0d] got %h want %h", name, w, rf[w], exp_w);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, bus_req, mem_rd, blk_we, err} !== 6'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL reset_state got %b addr=%h want 000000 0", {busy, done, bus_req, mem_rd, blk_we, err}, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bus_req, mem_rd, blk_we, err} !== 6'b0) begin
            errors++; $display("FAIL idle_after_reset got %b want 000000", {busy, done, bus_req, mem_rd, blk_we, err});
        end
        $display("reset released busy=%b bus_req=%b", busy, bus_req);
    endtask

    task automatic test_origin();
        int   k;
        logic [ADDR_W-1:0] exp_a [6];
        int   idx [6];
        run_load(0, 0, 20'h0, 0, 0, "origin");
        exp_a = '{20'd0, 20'd1, 20'd128, 20'd129, 20'd1920, 20'd1921};
        idx   = '{0, 1, 2, 3, 30, 31};
        for (int i = 0; i < 6; i++) begin
            k = idx[i];
            checks++;
            if (addr_log[k] !== exp_a[i]) begin
                errors++; $display("FAIL origin_const addr[%0d] got %0d want %0d", k, addr_log[k], exp_a[i]);
            end
        end
        check_rf(0, 0, 20'h0, "origin");
    endtask

    task automatic test_coords();
        run_load(3, 2, 20'h100, 0, 0, "coords");
        checks++;
        if (addr_log[0] !== 20'h01106) begin errors++; $display("FAIL coords_first got %h want 01106", addr_log[0]); end
        checks++;
        if (addr_log[31] !== 20'h01887) begin errors++; $display("FAIL coords_last got %h want 01887", addr_log[31]); end
        check_rf(3, 2, 20'h100, "coords");
    endtask

    task automatic test_gnt_delay();
        run_load(1, 4, 20'h2000, 10, 0, "gnt_delay");
        check_rf(1, 4, 20'h2000, "gnt_delay");
    endtask

    task automatic test_start_in_done();
        run_load(7, 1, 20'h0400, 2, 2, "start_in_done");
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL start_in_done extra_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        run_load(5, 7, 20'hFFF00, 0, 0, "b2b_wrap");
        check_rf(5, 7, 20'hFFF00, "b2b_wrap");
        run_load(63, 1, 20'h00010, 1, 0, "b2b_edge");
        check_rf(63, 1, 20'h00010, "b2b_edge");
    endtask

    task automatic test_start_in_read();
        logic exp_err;
`ifdef CUR_LOAD_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", err); end
        run_load(2, 3, 20'h0800, 0, 1, "start_in_read");
        check_rf(2, 3, 20'h0800, "start_in_read");
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL err_set got %b want %b", err, exp_err); end
        run_load(4, 0, 20'h0000, 0, 0, "after_err");
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL err_sticky got %b want %b", err, exp_err); end
    endtask

    task automatic test_reset_mid_load();
        int   nb, to, dn;
        logic hit;
        @(negedge clk);
        mb_x = 8'd6; mb_y = 8'd5; base_addr = 20'h0300; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus_gnt = 1'b1;
        nb = 0; to = 0; hit = 1'b0;
        while (!hit && to < 60) begin
            @(negedge clk); to++;
            if (mem_rd) begin
                if (nb == 15) hit = 1'b1;
                nb++;
            end
        end
        checks++;
        if (hit !== 1'b1) begin errors++; $display("FAIL mid_reset beat15_reached got %b want 1", hit); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus_req, mem_rd, blk_we, err} !== 6'b0 || mem_addr !== '0) begin
            errors++; $display("FAIL mid_reset outputs got %b addr=%h want 000000 0", {busy, done, bus_req, mem_rd, blk_we, err}, mem_addr);
        end
        @(negedge clk);
        bus_gnt = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy || bus_req) dn++;
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL mid_reset activity_after got %0d want 0", dn); end
        $display("reset at beat 15, quiet cycles after release");
        run_load(6, 5, 20'h0300, 0, 0, "after_reset");
        check_rf(6, 5, 20'h0300, "after_reset");
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; bus_gnt = 1'b0;
        mb_x = '0; mb_y = '0; base_addr = '0;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        mon_clr = 1'b0;
        test_reset();
        test_origin();
        test_coords();
        test_gnt_delay();
        test_start_in_done();
        test_back_to_back();
        test_start_in_read();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
